// File: rtl/mips_decode_alu_unit.sv
// rtl/mips_decode_alu_unit.sv - MIPS main decoder, ALU-control decoder, ALU and EX->MEM result register
// Optional XOR operation enabled by defining MIPS_ALU_XOR_EN.
module mips_decode_alu_unit #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [1:0]   aluop_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         regdst,
    output logic         branch_eq,
    output logic         branch_ne,
    output logic         memread,
    output logic         memtoreg,
    output logic         memwrite,
    output logic         alusrc,
    output logic         regwrite,
    output logic         jump,
    output logic [1:0]   aluop,
    output logic [3:0]   aluctl,
    output logic [W-1:0] result,
    output logic         zero,
    output logic [W-1:0] result_q,
    output logic         zero_q
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;
    localparam logic [3:0] CTL_XOR = 4'b1101;

    logic [W-1:0] result_d;
    logic         zero_d;

    // Unknown opcodes decode to all-zero controls so they behave as a bubble.
    always_comb begin
        regdst    = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        memread   = 1'b0;
        memtoreg  = 1'b0;
        memwrite  = 1'b0;
        alusrc    = 1'b0;
        regwrite  = 1'b0;
        jump      = 1'b0;
        aluop     = 2'b00;
        case (opcode)
            OP_RTYPE: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                aluop    = 2'b10;
            end
            OP_LW: begin
                memread  = 1'b1;
                memtoreg = 1'b1;
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            OP_SW: begin
                memwrite = 1'b1;
                alusrc   = 1'b1;
            end
            OP_ADDI: begin
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            OP_BEQ: begin
                branch_eq = 1'b1;
                aluop     = 2'b01;
            end
            OP_BNE: begin
                branch_ne = 1'b1;
                aluop     = 2'b01;
            end
            OP_J: begin
                jump = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        aluctl = CTL_ADD;
        case (aluop_in)
            2'b01: aluctl = CTL_SUB;
            2'b10: begin
                case (funct)
                    6'b100000: aluctl = CTL_ADD;
                    6'b100010: aluctl = CTL_SUB;
                    6'b100100: aluctl = CTL_AND;
                    6'b100101: aluctl = CTL_OR;
                    6'b100111: aluctl = CTL_NOR;
                    6'b101010: aluctl = CTL_SLT;
`ifdef MIPS_ALU_XOR_EN
                    6'b100110: aluctl = CTL_XOR;
`endif
                    default:   aluctl = CTL_AND;
                endcase
            end
            default: aluctl = CTL_ADD;
        endcase
    end

    always_comb begin
        result = '0;
        case (aluctl)
            CTL_AND: result = a & b;
            CTL_OR:  result = a | b;
            CTL_ADD: result = a + b;
            CTL_SUB: result = a - b;
            CTL_NOR: result = ~(a | b);
            CTL_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef MIPS_ALU_XOR_EN
            CTL_XOR: result = a ^ b;
`endif
            default: result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign result_d = result;
    assign zero_d   = zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_mips_decode_alu_unit.sv
// tb/tb_mips_decode_alu_unit.sv - table-driven bench for mips_decode_alu_unit
module tb_mips_decode_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [1:0]  aluop_in;
    logic [31:0] a, b;
    logic        regdst, branch_eq, branch_ne, memread, memtoreg, memwrite, alusrc, regwrite, jump;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] result, result_q;
    logic        zero, zero_q;

    int n_tests = 0;
    int n_fail  = 0;

    mips_decode_alu_unit #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .aluop_in(aluop_in),
        .a(a), .b(b), .regdst(regdst), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc),
        .regwrite(regwrite), .jump(jump), .aluop(aluop), .aluctl(aluctl),
        .result(result), .zero(zero), .result_q(result_q), .zero_q(zero_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [1:0]  aluop_in;
        logic [31:0] a;
        logic [31:0] b;
        logic [8:0]  ctrl;   // {regdst,branch_eq,branch_ne,memread,memtoreg,memwrite,alusrc,regwrite,jump}
        logic [1:0]  aluop;
        logic [3:0]  aluctl;
        logic [31:0] result;
        logic        zero;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{6'b000000, 6'b101010, 2'b10, 32'hFFFFFFFF, 32'h00000001, 9'b100000010, 2'b10, 4'b0111, 32'h00000001, 1'b0};
        vecs[1]  = '{6'b100011, 6'b101010, 2'b10, 32'h00000001, 32'hFFFFFFFF, 9'b000110110, 2'b00, 4'b0111, 32'h00000000, 1'b1};
        vecs[2]  = '{6'b101011, 6'b000000, 2'b01, 32'h00001234, 32'h00001234, 9'b000001100, 2'b00, 4'b0110, 32'h00000000, 1'b1};
        vecs[3]  = '{6'b001000, 6'b000000, 2'b00, 32'hFFFFFFFF, 32'h00000001, 9'b000000110, 2'b00, 4'b0010, 32'h00000000, 1'b1};
        vecs[4]  = '{6'b000100, 6'b100111, 2'b10, 32'h00000000, 32'h00000000, 9'b010000000, 2'b01, 4'b1100, 32'hFFFFFFFF, 1'b0};
        vecs[5]  = '{6'b000101, 6'b100000, 2'b10, 32'h00000005, 32'h00000007, 9'b001000000, 2'b01, 4'b0010, 32'h0000000C, 1'b0};
        vecs[6]  = '{6'b000010, 6'b100010, 2'b10, 32'h00000005, 32'h00000007, 9'b000000001, 2'b00, 4'b0110, 32'hFFFFFFFE, 1'b0};
        vecs[7]  = '{6'b111111, 6'b100100, 2'b10, 32'hF0F0F0F0, 32'hFFFF0000, 9'b000000000, 2'b00, 4'b0000, 32'hF0F00000, 1'b0};
        vecs[8]  = '{6'b001111, 6'b100101, 2'b10, 32'hF0F00000, 32'h0000000F, 9'b000000000, 2'b00, 4'b0001, 32'hF0F0000F, 1'b0};
        vecs[9]  = '{6'b000000, 6'b000000, 2'b11, 32'h7FFFFFFF, 32'h00000001, 9'b100000010, 2'b10, 4'b0010, 32'h80000000, 1'b0};
        vecs[10] = '{6'b000000, 6'b000000, 2'b10, 32'h00000003, 32'h00000005, 9'b100000010, 2'b10, 4'b0000, 32'h00000001, 1'b0};
`ifdef MIPS_ALU_XOR_EN
        vecs[11] = '{6'b000000, 6'b100110, 2'b10, 32'hF0F0F0F0, 32'hFFFF0000, 9'b100000010, 2'b10, 4'b1101, 32'h0F0FF0F0, 1'b0};
`else
        vecs[11] = '{6'b000000, 6'b100110, 2'b10, 32'hF0F0F0F0, 32'hFFFF0000, 9'b100000010, 2'b10, 4'b0000, 32'hF0F00000, 1'b0};
`endif
        vecs[12] = '{6'b000000, 6'b101010, 2'b10, 32'h80000000, 32'h7FFFFFFF, 9'b100000010, 2'b10, 4'b0111, 32'h00000001, 1'b0};
        vecs[13] = '{6'b000000, 6'b101010, 2'b10, 32'h00000005, 32'h00000005, 9'b100000010, 2'b10, 4'b0111, 32'h00000000, 1'b1};
        vecs[14] = '{6'b101011, 6'b100010, 2'b01, 32'h00000000, 32'h00000001, 9'b000001100, 2'b00, 4'b0110, 32'hFFFFFFFF, 1'b0};

        rst_n = 1'b0; opcode = '0; funct = '0; aluop_in = '0; a = '0; b = '0;
        #3;
        chk("reset result_q", result_q, 32'h0);
        chk("reset zero_q", {31'b0, zero_q}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            opcode = vecs[i].opcode; funct = vecs[i].funct; aluop_in = vecs[i].aluop_in;
            a = vecs[i].a; b = vecs[i].b;
            #1;
            chk($sformatf("v%0d ctrl", i),
                {23'b0, regdst, branch_eq, branch_ne, memread, memtoreg, memwrite, alusrc, regwrite, jump},
                {23'b0, vecs[i].ctrl});
            chk($sformatf("v%0d aluop", i), {30'b0, aluop}, {30'b0, vecs[i].aluop});
            chk($sformatf("v%0d aluctl", i), {28'b0, aluctl}, {28'b0, vecs[i].aluctl});
            chk($sformatf("v%0d result", i), result, vecs[i].result);
            chk($sformatf("v%0d zero", i), {31'b0, zero}, {31'b0, vecs[i].zero});
        end

        // Latency and reset mid-stream.
        opcode = 6'b000000; aluop_in = 2'b00; a = 32'd1; b = 32'd2;
        @(posedge clk); #1;
        chk("seq add result_q", result_q, 32'd3);
        chk("seq add zero_q", {31'b0, zero_q}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset result_q", result_q, 32'h0);
        chk("async reset zero_q", {31'b0, zero_q}, 32'h0);
        a = 32'd0; b = 32'd0;
        @(posedge clk); #1;
        chk("held reset zero_q", {31'b0, zero_q}, 32'h0);
        chk("comb zero in reset", {31'b0, zero}, 32'h1);
        rst_n = 1'b1;
        aluop_in = 2'b01; a = 32'd9; b = 32'd1;
        #1;
        chk("post release pre-edge result_q", result_q, 32'h0);
        @(posedge clk); #1;
        chk("post release result_q", result_q, 32'd8);
        chk("post release zero_q", {31'b0, zero_q}, 32'h0);

        aluop_in = 2'b01; a = 32'h1234; b = 32'h1234;
        #1;
        chk("sub zero comb", {31'b0, zero}, 32'h1);
        chk("sub zero_q pre-edge", {31'b0, zero_q}, 32'h0);
        @(posedge clk); #1;
        chk("sub zero_q", {31'b0, zero_q}, 32'h1);
        chk("sub result_q", result_q, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
